nes_controller_responder: RTL and testbench

Controller-side end of the NES serial pad link: emulates a standard NES pad so an FPGA board can act as a controller for a console or for the host-side pad reader in the same design. Samples an 8-bit button vector while CONTROLLER_LATCH is high, then shifts it out active-low on CONTROLLER_DATA, one bit per rising edge of CONTROLLER_PULSE. Runs entirely in the pixelClock domain; the latch and pulse inputs are asynchronous and are synchronized internally.

---
 rtl/nes_controller_responder.sv | 194 +++++++++++++++++++
 tb/tb_nes_controller_responder.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_controller_responder.sv
// nes_controller_responder
// ------------------------
// Emulates a standard NES pad on the controller side of the serial link.
// While the (synchronized) latch is high the button vector is loaded,
// inverted, into an 8-bit shift register every cycle. After the latch drops,
// each synchronized rising edge of the pulse input shifts the register right
// and inserts a 1 at the top. CONTROLLER_DATA is always shift register bit 0.
//
// Handshake: this block has no valid/ready pair. The link is a plain
// level/edge protocol. A latch level loads the register. A pulse rising edge
// shifts it. The latch always takes priority over the pulse.
//
// Parameters
//   SYNC_STAGES   flip-flop stages per asynchronous input (2..4)
//   TURBO_PERIOD  latch frames per turbo half-cycle (1..15), turbo build only
//
// Optional feature macro: NES_RESPONDER_TURBO_EN (adds turbo port and logic)
//
// Ports
//   pixelClock        in   design clock
//   resetN            in   asynchronous active-low reset
//   buttons[7:0]      in   pressed = 1 (A,B,Select,Start,Up,Down,Left,Right)
//   turbo[1:0]        in   turbo enables for A / B (turbo build only)
//   CONTROLLER_LATCH  in   asynchronous latch, active high
//   CONTROLLER_PULSE  in   asynchronous shift clock, active high
//   CONTROLLER_DATA   out  serial data, active low
//   readCount[3:0]    out  bits shifted since last latch, saturates at 8
//   frameDone         out  one-cycle pulse as readCount goes 7 -> 8
module nes_controller_responder #(
    parameter int SYNC_STAGES  = 2,
    parameter int TURBO_PERIOD = 2
) (
    input  logic       pixelClock,
    input  logic       resetN,
    input  logic [7:0] buttons,
`ifdef NES_RESPONDER_TURBO_EN
    input  logic [1:0] turbo,
`endif
    input  logic       CONTROLLER_LATCH,
    input  logic       CONTROLLER_PULSE,
    output logic       CONTROLLER_DATA,
    output logic [3:0] readCount,
    output logic       frameDone
);

    // Elaboration-time parameter range checks.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES out of range 2..4");
    end
    if (TURBO_PERIOD < 1 || TURBO_PERIOD > 15) begin : g_bad_turbo
        $error("TURBO_PERIOD out of range 1..15");
    end

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOADING  = 2'd1,
        ST_SHIFTING = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] latch_sync_q;
    logic [SYNC_STAGES-1:0] pulse_sync_q;
    logic                   latch_hist_q;
    logic                   pulse_hist_q;
    logic                   pulse_rise_q;
    logic                   latch_s;
    logic                   pulse_s;
    logic                   latch_fall;

    assign latch_s    = latch_sync_q[SYNC_STAGES-1];
    assign pulse_s    = pulse_sync_q[SYNC_STAGES-1];
    assign latch_fall = latch_hist_q & ~latch_s;

    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            latch_sync_q <= '0;
            pulse_sync_q <= '0;
            latch_hist_q <= 1'b0;
            pulse_hist_q <= 1'b0;
            pulse_rise_q <= 1'b0;
        end else begin
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], CONTROLLER_LATCH};
            pulse_sync_q <= {pulse_sync_q[SYNC_STAGES-2:0], CONTROLLER_PULSE};
            latch_hist_q <= latch_s;
            pulse_hist_q <= pulse_s;
            // Registered edge strobe: this cycle of delay keeps the pin to
            // data latency at SYNC_STAGES + 2.
            pulse_rise_q <= pulse_s & ~pulse_hist_q;
        end
    end

    // ------------------------------------------------------------------
    // Effective buttons (turbo masking of A/B when compiled in)
    // ------------------------------------------------------------------
    logic [7:0] eff_buttons;

`ifdef NES_RESPONDER_TURBO_EN
    logic [3:0] turbo_cnt_q, turbo_cnt_d;
    logic       phase_q, phase_d;

    // Count completed latches; flip the phase every TURBO_PERIOD of them.
    always_comb begin
        turbo_cnt_d = turbo_cnt_q;
        phase_d     = phase_q;
        if (latch_fall) begin
            if (turbo_cnt_q + 4'd1 == 4'(TURBO_PERIOD)) begin
                turbo_cnt_d = 4'd0;
                phase_d     = ~phase_q;
            end else begin
                turbo_cnt_d = turbo_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            turbo_cnt_q <= 4'd0;
            phase_q     <= 1'b0;
        end else begin
            turbo_cnt_q <= turbo_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign eff_buttons = {buttons[7:2],
                          buttons[1] & (~turbo[1] | phase_q),
                          buttons[0] & (~turbo[0] | phase_q)};
`else
    assign eff_buttons = buttons;
`endif

    // ------------------------------------------------------------------
    // Frame FSM, shift register and read counter
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] count_q, count_d;
    logic       done_q, done_d;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (latch_s) begin
            // Latch wins over everything, including a half-read frame.
            state_d = ST_LOADING;
            shift_d = ~eff_buttons;
            count_d = 4'd0;
        end else begin
            unique case (state_q)
                ST_LOADING, ST_SHIFTING: begin
                    // Being in LOADING with the latch low is the falling edge.
                    state_d = ST_SHIFTING;
                    if (pulse_rise_q) begin
                        shift_d = {1'b1, shift_q[7:1]};
                        count_d = count_q + 4'd1;
                        if (count_q == 4'd7) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    // IDLE: keep shifting ones out, counter untouched.
                    if (pulse_rise_q) begin
                        shift_d = {1'b1, shift_q[7:1]};
                    end
                end
            endcase
        end
    end

    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            shift_q <= 8'hFF;
            count_q <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign CONTROLLER_DATA = shift_q[0];
    assign readCount       = count_q;
    assign frameDone       = done_q;

endmodule

// File: tb/tb_nes_controller_responder.sv
module tb_nes_controller_responder;
  localparam int S  = 2;
  localparam int TP = 1;

  logic       clk;
  logic       rst_n;
  logic [7:0] buttons;
  logic [1:0] turbo;
  logic       latch;
  logic       pulse;
  logic       data;
  logic [3:0] read_count;
  logic       frame_done;

  int checks;
  int failures;
  int fd_cnt;
  int latch_falls;
  logic [7:0] frame_m;

  nes_controller_responder #(
    .SYNC_STAGES (S),
    .TURBO_PERIOD(TP)
  ) dut (
    .pixelClock      (clk),
    .resetN          (rst_n),
    .buttons         (buttons),
`ifdef NES_RESPONDER_TURBO_EN
    .turbo           (turbo),
`endif
    .CONTROLLER_LATCH(latch),
    .CONTROLLER_PULSE(pulse),
    .CONTROLLER_DATA (data),
    .readCount       (read_count),
    .frameDone       (frame_done)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // frameDone is counted in high cycles so a stretched pulse shows up.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fd_cnt <= 0;
    else if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  // reference model: what a pad with these buttons presents
  function automatic logic [7:0] eff_model(input logic [7:0] b);
    logic [7:0] e;
    int phase;
    e = b;
    phase = (latch_falls / TP) % 2;
`ifdef NES_RESPONDER_TURBO_EN
    if (turbo[0] && phase == 0) e[0] = 1'b0;
    if (turbo[1] && phase == 0) e[1] = 1'b0;
`endif
    return e;
  endfunction

  // bit presented after n pulses of a frame whose pressed vector is f
  function automatic logic exp_data(input logic [7:0] f, input int n);
    return (n < 8) ? ~f[n] : 1'b1;
  endfunction

  function automatic logic [3:0] exp_count(input int n);
    return (n > 8) ? 4'd8 : 4'(n);
  endfunction

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_latch(input logic [7:0] b, input int high_cycles);
    buttons = b;
    wait_cycles(S + 2);
    latch = 1'b1;
    wait_cycles(high_cycles);
    frame_m = eff_model(b);
    latch = 1'b0;
    latch_falls++;
    wait_cycles(S + 3);
  endtask

  task automatic do_pulse(input int high_cycles, input int low_cycles);
    pulse = 1'b1;
    wait_cycles(high_cycles);
    pulse = 1'b0;
    wait_cycles(low_cycles);
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      latch = i[0];
      pulse = i[1];
      wait_cycles(1);
      checks++;
      if (data !== 1'b1 || read_count !== 4'd0 || frame_done !== 1'b0) begin
        failures++;
        $display("FAIL reset cycle %0d: data=%b count=%0d done=%b, want 1/0/0",
                 i, data, read_count, frame_done);
      end
    end
    latch = 1'b0;
    pulse = 1'b0;
    wait_cycles(4);
    rst_n = 1'b1;
    latch_falls = 0;
    wait_cycles(4);
    checks++;
    if (data !== 1'b1 || read_count !== 4'd0 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL reset release: data=%b count=%0d done=%b, want 1/0/0",
               data, read_count, frame_done);
    end
  endtask

  task automatic test_full_frame();
    logic [7:0] exp_bits;
    int fd0;
    exp_bits = 8'b0111_1010;  // samples 0,1,0,1,1,1,1,0 in bit order
    do_latch(8'b1000_0101, 480);
    fd0 = fd_cnt;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (data !== exp_bits[k] || read_count !== 4'(k)) begin
        failures++;
        $display("FAIL full_frame bit %0d: data=%b count=%0d, want %b/%0d",
                 k, data, read_count, exp_bits[k], k);
      end
      do_pulse(240, 240);
    end
    checks++;
    if (data !== 1'b1 || read_count !== 4'd8 || fd_cnt - fd0 !== 1) begin
      failures++;
      $display("FAIL full_frame end: data=%b count=%0d done_pulses=%0d, want 1/8/1",
               data, read_count, fd_cnt - fd0);
    end
  endtask

  task automatic test_overrun();
    int fd0;
    fd0 = fd_cnt;
    for (int k = 0; k < 2; k++) begin
      do_pulse(8, 8);
      checks++;
      if (data !== 1'b1 || read_count !== 4'd8) begin
        failures++;
        $display("FAIL overrun pulse %0d: data=%b count=%0d, want 1/8",
                 k + 9, data, read_count);
      end
    end
    checks++;
    if (fd_cnt - fd0 !== 0) begin
      failures++;
      $display("FAIL overrun done: pulses=%0d, want 0", fd_cnt - fd0);
    end
  endtask

  task automatic test_relatch();
    logic [7:0] exp_bits;
    int fd0;
    exp_bits = 8'b1110_1111;  // samples 1,1,1,1,0,1,1,1
    do_latch(8'hA5, 10);
    fd0 = fd_cnt;
    for (int k = 0; k < 3; k++) do_pulse(6, 6);
    checks++;
    if (read_count !== 4'd3) begin
      failures++;
      $display("FAIL relatch before: count=%0d, want 3", read_count);
    end
    do_latch(8'h10, 12);
    checks++;
    if (read_count !== 4'd0 || fd_cnt - fd0 !== 0) begin
      failures++;
      $display("FAIL relatch abort: count=%0d done_pulses=%0d, want 0/0",
               read_count, fd_cnt - fd0);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (data !== exp_bits[k]) begin
        failures++;
        $display("FAIL relatch bit %0d: data=%b, want %b", k, data, exp_bits[k]);
      end
      do_pulse(6, 6);
    end
    checks++;
    if (read_count !== 4'd8 || fd_cnt - fd0 !== 1) begin
      failures++;
      $display("FAIL relatch end: count=%0d done_pulses=%0d, want 8/1",
               read_count, fd_cnt - fd0);
    end
  endtask

  task automatic test_button_change();
    buttons = 8'h01;
    wait_cycles(S + 2);
    latch = 1'b1;
    wait_cycles(10);
    frame_m = eff_model(8'h01);
    latch = 1'b0;
    latch_falls++;
    wait_cycles(2);
    buttons = 8'h00;
    wait_cycles(S + 3);
    checks++;
    if (data !== exp_data(frame_m, 0)) begin
      failures++;
      $display("FAIL button_change first bit: data=%b, want %b",
               data, exp_data(frame_m, 0));
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int np;
    int fd0;
    for (int f = 0; f < 20; f++) begin
      b  = 8'($urandom_range(0, 255));
      np = $urandom_range(0, 11);
      do_latch(b, $urandom_range(3, 20));
      fd0 = fd_cnt;
      checks++;
      if (data !== exp_data(frame_m, 0) || read_count !== 4'd0) begin
        failures++;
        $display("FAIL random f%0d load: data=%b count=%0d, want %b/0",
                 f, data, read_count, exp_data(frame_m, 0));
      end
      for (int k = 0; k < np; k++) begin
        do_pulse($urandom_range(S + 1, 8), $urandom_range(S + 2, 8));
        checks++;
        if (data !== exp_data(frame_m, k + 1) || read_count !== exp_count(k + 1)) begin
          failures++;
          $display("FAIL random f%0d pulse %0d: data=%b count=%0d, want %b/%0d",
                   f, k + 1, data, read_count, exp_data(frame_m, k + 1),
                   exp_count(k + 1));
        end
      end
      wait_cycles(4);
      checks++;
      if (fd_cnt - fd0 !== ((np >= 8) ? 1 : 0)) begin
        failures++;
        $display("FAIL random f%0d done: pulses=%0d, want %0d",
                 f, fd_cnt - fd0, (np >= 8) ? 1 : 0);
      end
    end
  endtask

`ifdef NES_RESPONDER_TURBO_EN
  task automatic test_turbo();
    turbo = 2'b01;
    for (int f = 0; f < 4; f++) begin
      do_latch(8'h03, 10);
      checks++;
      if (data !== exp_data(frame_m, 0)) begin
        failures++;
        $display("FAIL turbo f%0d A: data=%b, want %b", f, data, exp_data(frame_m, 0));
      end
      do_pulse(6, 6);
      checks++;
      if (data !== 1'b0) begin
        failures++;
        $display("FAIL turbo f%0d B: data=%b, want 0", f, data);
      end
      for (int k = 1; k < 8; k++) do_pulse(4, 4);
    end
    turbo = 2'b00;
  endtask
`endif

  initial begin
    checks      = 0;
    failures    = 0;
    latch_falls = 0;
    frame_m     = 8'h00;
    buttons     = 8'h00;
    turbo       = 2'b00;
    latch       = 1'b0;
    pulse       = 1'b0;
    rst_n       = 1'b0;
    test_reset();
    test_full_frame();
    test_overrun();
    test_relatch();
    test_button_change();
    test_random();
`ifdef NES_RESPONDER_TURBO_EN
    test_turbo();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
